// File: rtl/vend_controller.sv
// Coin vending sequencer: credit, price check, dispense and change handshakes.
// Optional macro TIMEOUT_REFUND_EN refunds idle credit after TIMEOUT_CYC cycles.
module vend_controller #(
    parameter int CREDIT_W    = 4,
    parameter int MAX_CREDIT  = 10,
    parameter int PRICE0      = 3,
    parameter int PRICE1      = 2,
    parameter int PRICE2      = 4,
    parameter int PRICE3      = 1,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin,
    input  logic                sel_valid,
    input  logic [1:0]          sel_id,
    input  logic                cancel,
    input  logic                dispense_ack,
    input  logic                pay_ack,
    output logic                dispense_req,
    output logic [1:0]          dispense_id,
    output logic                pay_req,
    output logic [1:0]          pay_coin,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject,
    output logic                insufficient
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CREDIT = 2'd1;
    localparam logic [1:0] VEND   = 2'd2;
    localparam logic [1:0] PAY    = 2'd3;

    logic [1:0]          state;
    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W-1:0] price;
    logic [CREDIT_W-1:0] step;
    logic [1:0]          coin_val;
    logic                coin_live;
    logic                coin_ok;
    logic                accepting;
    logic                in_credit;
    logic                afford;
    logic                do_cancel;
    logic                do_sel;
    logic                sel_refused;
    logic                take_coin;
    logic                timeout;

    // credit doubles as the change remainder once a vend or refund starts
    assign busy = state[1];

`ifdef TIMEOUT_REFUND_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] idle_cnt;
    logic          activity;

    assign activity = coin_valid | sel_valid | cancel;
    assign timeout  = (state == CREDIT) && !activity &&
                      (idle_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (state != CREDIT || activity || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign unused_cfg = |TIMEOUT_CYC;
`endif

    always_comb begin
        price = CREDIT_W'(PRICE0);
        unique case (sel_id)
            2'd0: price = CREDIT_W'(PRICE0);
            2'd1: price = CREDIT_W'(PRICE1);
            2'd2: price = CREDIT_W'(PRICE2);
            2'd3: price = CREDIT_W'(PRICE3);
        endcase
        coin_live = coin_valid && (coin != 2'b00);
        coin_val  = (coin == 2'b01) ? 2'd1 :
                    (coin == 2'b10) ? 2'd2 : 2'd0;
        sum       = {1'b0, credit} + (CREDIT_W+1)'(coin_val);
        coin_ok   = coin_live && (coin != 2'b11) &&
                    (sum <= (CREDIT_W+1)'(MAX_CREDIT));
        accepting = !state[1];
        in_credit = (state == CREDIT);
        afford    = (credit >= price);
        do_cancel = in_credit && (cancel || timeout);
        do_sel    = in_credit && sel_valid && afford && !do_cancel;
        // price is never zero, so an IDLE selection is always refused
        sel_refused = accepting && sel_valid && !afford && !do_cancel;
        take_coin   = accepting && coin_ok && !do_cancel && !do_sel;
        step = (credit >= CREDIT_W'(2)) ? CREDIT_W'(2) : CREDIT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            credit       <= '0;
            dispense_req <= 1'b0;
            dispense_id  <= 2'b00;
            pay_req      <= 1'b0;
            pay_coin     <= 2'b00;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
        end else begin
            coin_reject  <= coin_live && !take_coin;
            insufficient <= sel_refused;
            unique case (state)
                IDLE, CREDIT: begin
                    if (do_cancel) begin
                        state <= PAY;
                    end else if (do_sel) begin
                        credit       <= credit - price;
                        dispense_id  <= sel_id;
                        dispense_req <= 1'b1;
                        state        <= VEND;
                    end else if (take_coin) begin
                        credit <= sum[CREDIT_W-1:0];
                        state  <= CREDIT;
                    end
                end
                VEND: begin
                    if (dispense_req && dispense_ack) begin
                        dispense_req <= 1'b0;
                        state <= (credit != '0) ? PAY : IDLE;
                    end
                end
                PAY: begin
                    // one idle cycle separates successive coin requests
                    if (pay_req) begin
                        if (pay_ack) begin
                            pay_req <= 1'b0;
                            credit  <= credit - step;
                            if (credit == step) begin
                                state <= IDLE;
                            end
                        end
                    end else begin
                        pay_req  <= 1'b1;
                        pay_coin <= (step == CREDIT_W'(2)) ? 2'b10 : 2'b01;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: vends, change, refusals, cancel, reset.
// Adds an idle-refund case when TIMEOUT_REFUND_EN is defined.
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin = 2'b00;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_id = 2'b00;
    logic       cancel = 1'b0;
    logic       dispense_ack = 1'b0;
    logic       pay_ack = 1'b0;
    logic       dispense_req;
    logic [1:0] dispense_id;
    logic       pay_req;
    logic [1:0] pay_coin;
    logic [3:0] credit;
    logic       busy;
    logic       coin_reject;
    logic       insufficient;

    int vecs = 0;
    int errs = 0;

    vend_controller dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .coin_valid   (coin_valid),
        .coin         (coin),
        .sel_valid    (sel_valid),
        .sel_id       (sel_id),
        .cancel       (cancel),
        .dispense_ack (dispense_ack),
        .pay_ack      (pay_ack),
        .dispense_req (dispense_req),
        .dispense_id  (dispense_id),
        .pay_req      (pay_req),
        .pay_coin     (pay_coin),
        .credit       (credit),
        .busy         (busy),
        .coin_reject  (coin_reject),
        .insufficient (insufficient)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [1:0] c);
        coin_valid = 1'b1;
        coin = c;
        tick();
        coin_valid = 1'b0;
        coin = 2'b00;
    endtask

    task automatic select(input logic [1:0] s);
        sel_valid = 1'b1;
        sel_id = s;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic vend_ack(input string tag, input int exp_cr);
        dispense_ack = 1'b1;
        tick();
        dispense_ack = 0;
        chk({tag, "_dreq_drop"}, dispense_req, 0);
        chk({tag, "_cr"}, credit, exp_cr);
    endtask

    task automatic pay_one(input string tag, input logic [1:0] exp_coin,
                           input int exp_cr);
        int n = 0;
        while (!pay_req && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, pay_req, 1);
        chk({tag, "_coin"}, pay_coin, exp_coin);
        pay_ack = 1'b1;
        tick();
        pay_ack = 1'b0;
        chk({tag, "_drop"}, pay_req, 0);
        chk({tag, "_cr"}, credit, exp_cr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_credit", credit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dreq", dispense_req, 0);
        chk("rst_preq", pay_req, 0);
        chk("rst_rej", coin_reject, 0);
        reset_n = 1'b1;
        tick();

        // exact payment: 10 + 5 buys product 0
        put_coin(2'b10);
        chk("ex_cr2", credit, 2);
        put_coin(2'b01);
        chk("ex_cr3", credit, 3);
        chk("ex_busy0", busy, 0);
        select(2'd0);
        chk("ex_dreq", dispense_req, 1);
        chk("ex_did", dispense_id, 0);
        chk("ex_busy", busy, 1);
        chk("ex_rem", credit, 0);
        tick();
        chk("ex_dreq_hold", dispense_req, 1);
        vend_ack("ex", 0);
        chk("ex_idle", busy, 0);
        tick();
        chk("ex_nopay", pay_req, 0);

        // change: 30rs buys product 3, same-cycle coin rejected
        put_coin(2'b10);
        put_coin(2'b10);
        put_coin(2'b10);
        chk("ch_cr6", credit, 6);
        sel_valid = 1'b1;
        sel_id = 2'd3;
        coin_valid = 1'b1;
        coin = 2'b10;
        tick();
        sel_valid = 1'b0;
        coin_valid = 1'b0;
        chk("ch_did", dispense_id, 3);
        chk("ch_rem", credit, 5);
        chk("ch_rej", coin_reject, 1);
        vend_ack("ch", 5);
        chk("ch_busy", busy, 1);
        pay_one("ch_p1", 2'b10, 3);
        pay_one("ch_p2", 2'b10, 1);
        pay_one("ch_p3", 2'b01, 0);
        chk("ch_idle", busy, 0);

        // refused selection still credits a same-cycle coin
        put_coin(2'b01);
        chk("in_cr1", credit, 1);
        sel_valid = 1'b1;
        sel_id = 2'd2;
        coin_valid = 1'b1;
        coin = 2'b01;
        tick();
        sel_valid = 1'b0;
        coin_valid = 1'b0;
        chk("in_pulse", insufficient, 1);
        chk("in_rej", coin_reject, 0);
        chk("in_cr2", credit, 2);
        chk("in_busy", busy, 0);
        tick();
        chk("in_pulse_end", insufficient, 0);

        // saturation, illegal coin, empty coin, then full refund
        put_coin(2'b10);
        put_coin(2'b10);
        put_coin(2'b10);
        put_coin(2'b01);
        chk("sat_cr9", credit, 9);
        put_coin(2'b10);
        chk("sat_rej", coin_reject, 1);
        chk("sat_cr", credit, 9);
        put_coin(2'b11);
        chk("bad_rej", coin_reject, 1);
        chk("bad_cr", credit, 9);
        put_coin(2'b00);
        chk("none_rej", coin_reject, 0);
        chk("none_cr", credit, 9);
        do_cancel();
        chk("rf_busy", busy, 1);
        chk("rf_cr", credit, 9);
        pay_one("rf_p1", 2'b10, 7);
        pay_one("rf_p2", 2'b10, 5);
        pay_one("rf_p3", 2'b10, 3);
        pay_one("rf_p4", 2'b10, 1);
        pay_one("rf_p5", 2'b01, 0);
        chk("rf_idle", busy, 0);

        // coin and cancel while busy
        put_coin(2'b10);
        select(2'd3);
        chk("bz_did", dispense_id, 3);
        put_coin(2'b01);
        chk("bz_rej", coin_reject, 1);
        chk("bz_cr", credit, 1);
        do_cancel();
        chk("bz_cancel_ign", dispense_req, 1);
        vend_ack("bz", 1);
        pay_one("bz_p1", 2'b01, 0);
        chk("bz_idle", busy, 0);

        // idle-state corner cases
        select(2'd1);
        chk("idle_insuf", insufficient, 1);
        chk("idle_busy", busy, 0);
        do_cancel();
        chk("idle_cancel", busy, 0);
        dispense_ack = 1'b1;
        pay_ack = 1'b1;
        tick();
        dispense_ack = 1'b0;
        pay_ack = 1'b0;
        chk("stray_dreq", dispense_req, 0);
        chk("stray_preq", pay_req, 0);
        chk("stray_busy", busy, 0);

        // cancel beats a same-cycle coin
        put_coin(2'b10);
        put_coin(2'b10);
        cancel = 1'b1;
        coin_valid = 1'b1;
        coin = 2'b01;
        tick();
        cancel = 1'b0;
        coin_valid = 1'b0;
        chk("cc_rej", coin_reject, 1);
        chk("cc_busy", busy, 1);
        chk("cc_cr", credit, 4);
        pay_one("cc_p1", 2'b10, 2);
        pay_one("cc_p2", 2'b10, 0);
        chk("cc_idle", busy, 0);

        // asynchronous reset in the middle of a payout
        put_coin(2'b10);
        put_coin(2'b10);
        do_cancel();
        tick();
        chk("mr_req", pay_req, 1);
        reset_n = 1'b0;
        #2;
        chk("mr_preq", pay_req, 0);
        chk("mr_cr", credit, 0);
        chk("mr_busy", busy, 0);
        reset_n = 1'b1;
        pay_ack = 1'b1;
        tick();
        pay_ack = 1'b0;
        tick();
        chk("mr_after_busy", busy, 0);
        chk("mr_after_preq", pay_req, 0);

`ifdef TIMEOUT_REFUND_EN
        put_coin(2'b01);
        begin
            int n = 0;
            while (!pay_req && n < 1100) begin
                tick();
                n++;
            end
        end
        chk("to_req", pay_req, 1);
        chk("to_coin", pay_coin, 2'b01);
        pay_ack = 1'b1;
        tick();
        pay_ack = 1'b0;
        chk("to_cr", credit, 0);
        chk("to_idle", busy, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Top-level sequencer for a four-product coin vending machine.
- Accumulates coin credit in 5rs units, checks product selections against a price table, drives the dispenser mechanism through a req/ack handshake, and then pays out change coin-by-coin through a coin-hopper handshake.
- Sits between the coin acceptor and keypad on one side and the dispense motor and change hopper on the other.

Parameters:
- CREDIT_W, 4: width of the credit register, in 5rs units.
- MAX_CREDIT, 10: maximum credit held (10 = 50rs). Must be < 2**CREDIT_W.
- PRICE0, 3: price of product 0, in 5rs units (15rs).
- PRICE1, 2: price of product 1 (10rs).
- PRICE2, 4: price of product 2 (20rs).
- PRICE3, 1: price of product 3 (5rs).
- TIMEOUT_CYC, 1000: inactivity timeout in cycles. Used only with TIMEOUT_REFUND_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- coin_valid  input  1  one-cycle pulse; a coin is present on coin.
- coin  input  2  00=none, 01=5rs, 10=10rs, 11=invalid.
- sel_valid  input  1  one-cycle pulse; a product selection is present.
- sel_id  input  2  selected product index.
- cancel  input  1  one-cycle pulse; refund the full credit.
- dispense_ack  input  1  dispenser has completed the drop.
- pay_ack  input  1  hopper has ejected the requested coin.
- dispense_req  output  1  request to drop a product.
- dispense_id  output  2  product to drop; stable while dispense_req=1.
- pay_req  output  1  request to eject one change coin.
- pay_coin  output  2  01=5rs, 10=10rs; stable while pay_req=1.
- credit  output  CREDIT_W  current credit, in 5rs units.
- busy  output  1  high in VEND and PAY.
- coin_reject  output  1  one-cycle pulse; the coin was returned and not credited.
- insufficient  output  1  one-cycle pulse; the selection was refused for lack of credit.

Behaviour:
- Reset:
  - Asynchronous on reset_n=0; all outputs and registers go to 0 and state goes to IDLE.
  - Reset asserted mid-VEND or mid-PAY abandons the operation. Credit is lost; no ack is awaited.
- States: IDLE (credit=0), CREDIT, VEND, PAY. All outputs are registered.
- Coin handling in IDLE/CREDIT:
  - Valid coin (01 or 10): credit += 1 or 2 on the next edge, and the state becomes CREDIT.
  - Coin 00 with coin_valid=1: ignored.
  - Coin 11: coin_reject pulses.
  - Coin that would push credit above MAX_CREDIT: coin_reject pulses; credit is unchanged.
- Coin handling in VEND/PAY: any valid coin produces a coin_reject pulse.
- Selection in CREDIT:
  - sel_valid with credit >= PRICE[sel_id]: latch remain = credit - price and dispense_id = sel_id; assert dispense_req next cycle; go to VEND.
  - sel_valid with credit < price: insufficient pulses; state and credit are unchanged.
  - sel_valid in IDLE: insufficient pulses (price is always >= 1).
- Same-cycle priority in CREDIT: cancel > sel_valid > coin_valid.
  - An accepted selection or a cancel rejects a same-cycle coin (coin_reject pulses).
  - A refused selection still lets a same-cycle coin be credited.
- Cancel in CREDIT: remain = credit; go to PAY with no dispense. Cancel in IDLE, VEND or PAY is ignored.
- VEND:
  - Hold dispense_req and dispense_id until the dispense_ack edge.
  - dispense_req drops the cycle after the ack.
  - Then go to PAY if remain > 0, else go to IDLE.
  - No timeout applies in VEND.
- PAY:
  - Pay 10rs coins while remain >= 2, then one 5rs coin if remain = 1.
  - Hold pay_req and pay_coin until pay_ack. On ack, remain decrements by 2 or 1.
  - pay_req is low for at least one cycle between coins.
  - When remain = 0, go to IDLE.
- credit output: shows live credit in CREDIT, shows remain in VEND/PAY, and shows 0 in IDLE.
- Acks outside their matching request are ignored: dispense_ack when dispense_req=0, pay_ack when pay_req=0.

Optional Feature:
- Macro: TIMEOUT_REFUND_EN.
- Defined:
  - An inactivity counter runs in CREDIT and clears on any coin_valid, sel_valid or cancel.
  - When it reaches TIMEOUT_CYC, the block behaves as if cancel had been asserted and refunds via PAY.
- Undefined: no counter is built, and credit is held indefinitely.

Test Plan:
- Exact payment: coin 10 then 01 (credit=3), sel_id=0 -> dispense_req with id 0; after ack, no pay_req; IDLE with credit=0.
- Change: coins 10,10,10 (credit=6), sel_id=3 -> dispense id 3; then pay_req with pay_coin=10 twice, then 01 once; credit steps 5,3,1,0.
- Insufficient: credit=1, sel_id=2 -> insufficient pulse; credit stays 1; a same-cycle coin 01 is credited to give credit=2.
- Saturation and illegal coin: credit=9, coin 10 -> coin_reject; credit=9. Coin 11 -> coin_reject.
- Busy rejection and cancel: coin 01 during VEND -> coin_reject. Credit=4 plus cancel -> pays 10,10, then IDLE.
- Reset mid-PAY: reset_n low while pay_req=1 -> pay_req=0 immediately; credit=0; IDLE. With TIMEOUT_REFUND_EN defined, credit=1 and TIMEOUT_CYC idle cycles -> pay_req with pay_coin=01.
